// File: rtl/intctrl.sv
// Parametrised interrupt controller: rising-edge capture into IF, IE mask, IME with
// delayed enable, priority vectoring to the CPU and a HALT wake output.
module intctrl #(
  parameter int          NINT       = 5,
  parameter logic [15:0] IF_ADDR    = 16'hff0f,
  parameter logic [15:0] IE_ADDR    = 16'hffff,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
  input  logic            clockgb,
  input  logic            resetn,
  input  logic [15:0]     address,
  input  logic [7:0]      indata,
  output logic [7:0]      outdata,
  input  logic            load,
  input  logic            store,
  input  logic [NINT-1:0] interrupts,
  input  logic            ime_set,
  input  logic            ime_clr,
  output logic            intreq,
  output logic [15:0]     intaddress,
  input  logic            intack,
  output logic            wake,
  output logic [NINT-1:0] dints
);

  logic [NINT-1:0] if_q, if_d;
  logic [NINT-1:0] ie_q, ie_d;
  logic [NINT-1:0] prev_q;
  logic            ime_q, ime_d;
  logic            ime_pend_q, ime_pend_d;

  logic [NINT-1:0] rise, pend, win_oh;
  logic [2:0]      win;
  logic [15:0]     vec;
  logic            ack, wr_if, wr_ie;
  logic [7:0]      if_rd, ie_rd;
  logic            unused_indata;

  assign rise  = interrupts & ~prev_q;
  assign pend  = if_q & ie_q;
  assign wr_if = store && (address == IF_ADDR);
  assign wr_ie = store && (address == IE_ADDR);

  // Scan from the top so the lowest pending index is the one left standing.
  always_comb begin
    win    = '0;
    win_oh = '0;
    for (int i = NINT - 1; i >= 0; i--) begin
      if (pend[i]) begin
        win       = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign vec        = VEC_BASE + (16'(win) * VEC_STRIDE);
  assign wake       = |pend;
  assign intreq     = ime_q & (|pend);
  assign intaddress = intreq ? vec : 16'h0000;
  assign ack        = intack & intreq;
  assign dints      = if_q;

  // Hardware rises are OR-ed in last so they survive an ack clear or a write of 0.
  always_comb begin
    if_d = if_q;
    if (ack)   if_d = if_d & ~win_oh;
    if (wr_if) if_d = indata[NINT-1:0];
    if_d = if_d | rise;
  end

  assign ie_d = wr_ie ? indata[NINT-1:0] : ie_q;

  // Ack beats DI, DI beats EI; a pending EI becomes IME on the following edge.
  always_comb begin
    ime_d      = ime_q;
    ime_pend_d = ime_pend_q;
    if (ack || ime_clr) begin
      ime_d      = 1'b0;
      ime_pend_d = 1'b0;
    end else begin
      if (ime_pend_q) ime_d = 1'b1;
      ime_pend_d = ime_set;
    end
  end

  always_comb begin
    if_rd             = '1;
    if_rd[NINT-1:0]   = if_q;
    ie_rd             = '0;
    ie_rd[NINT-1:0]   = ie_q;
  end

  always_comb begin
    outdata = 8'h00;
    if (resetn && load) begin
      if (address == IF_ADDR)      outdata = if_rd;
      else if (address == IE_ADDR) outdata = ie_rd;
    end
  end

  assign unused_indata = ^indata;

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      if_q       <= '0;
      ie_q       <= '0;
      prev_q     <= '0;
      ime_q      <= 1'b0;
      ime_pend_q <= 1'b0;
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      prev_q     <= interrupts;
      ime_q      <= ime_d;
      ime_pend_q <= ime_pend_d;
    end
  end

endmodule

// File: tb/tb_intctrl.sv
// Bench for intctrl: directed vector table, hand sequences for multi-cycle corners,
// an 8-source instance, and randomized traffic against a rule-level reference model.
module tb_intctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] address;
  logic [7:0]  indata;
  logic        load, store, ime_set, ime_clr, intack;
  logic [4:0]  ints;
  logic [7:0]  outdata;
  logic        intreq, wake;
  logic [15:0] intaddress;
  logic [4:0]  dints;

  logic [15:0] a8;
  logic [7:0]  d8, od8, ints8, di8;
  logic        ld8, st8, is8, ic8, ack8, rq8, wk8;
  logic [15:0] ia8;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  intctrl u_dut (
    .clockgb(clk), .resetn(resetn), .address(address), .indata(indata),
    .outdata(outdata), .load(load), .store(store), .interrupts(ints),
    .ime_set(ime_set), .ime_clr(ime_clr), .intreq(intreq),
    .intaddress(intaddress), .intack(intack), .wake(wake), .dints(dints)
  );

  intctrl #(.NINT(8), .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010)) u_dut8 (
    .clockgb(clk), .resetn(resetn), .address(a8), .indata(d8),
    .outdata(od8), .load(ld8), .store(st8), .interrupts(ints8),
    .ime_set(is8), .ime_clr(ic8), .intreq(rq8),
    .intaddress(ia8), .intack(ack8), .wake(wk8), .dints(di8)
  );

  typedef struct {
    logic        st;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        ld;
    logic [4:0]  ints;
    logic        set, clr, ack;
    logic        e_req;
    logic [15:0] e_vec;
    logic        e_wake;
    logic [4:0]  e_if;
    logic [7:0]  e_out;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    store = 1'b0; ime_set = 1'b0; ime_clr = 1'b0; intack = 1'b0;
    st8 = 1'b0; is8 = 1'b0; ic8 = 1'b0; ack8 = 1'b0;
  endtask

  task automatic chk_main(input string nm, input logic req, input logic [15:0] v,
                          input logic wk, input logic [4:0] fl);
    chk({nm, ".intreq"}, 32'(intreq), 32'(req));
    chk({nm, ".intaddress"}, 32'(intaddress), 32'(v));
    chk({nm, ".wake"}, 32'(wake), 32'(wk));
    chk({nm, ".dints"}, 32'(dints), 32'(fl));
  endtask

  // Reference model: IF/IE as bit sets, IME as a flag plus a one-edge EI delay.
  bit [4:0] m_if, m_ie, m_prev;
  bit       m_ime, m_pend;

  function automatic int m_winner();
    for (int i = 0; i < 5; i++)
      if (m_if[i] && m_ie[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_if = '0; m_ie = '0; m_prev = '0; m_ime = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_check(input int cyc);
    int          w;
    logic        e_req;
    logic [15:0] e_vec;
    logic [7:0]  e_out;
    string       nm;
    w     = m_winner();
    e_req = m_ime && (w >= 0);
    e_vec = e_req ? 16'(32'h0040 + w * 8) : 16'h0000;
    e_out = 8'h00;
    if (load && address == 16'hff0f)      e_out = {3'b111, m_if};
    else if (load && address == 16'hffff) e_out = {3'b000, m_ie};
    nm = $sformatf("rnd%0d", cyc);
    chk_main(nm, e_req, e_vec, w >= 0, m_if);
    chk({nm, ".outdata"}, 32'(outdata), 32'(e_out));
  endtask

  task automatic model_step();
    int       w;
    bit [4:0] n_if;
    w    = m_winner();
    n_if = m_if;
    if (intack && m_ime && w >= 0) n_if[w] = 1'b0;
    if (store && address == 16'hff0f) n_if = indata[4:0];
    n_if = n_if | (ints & ~m_prev);
    if (store && address == 16'hffff) m_ie = indata[4:0];
    if ((intack && m_ime && w >= 0) || ime_clr) begin
      m_ime  = 1'b0;
      m_pend = 1'b0;
    end else begin
      m_ime  = m_ime || m_pend;
      m_pend = ime_set;
    end
    m_if   = n_if;
    m_prev = ints;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    address = '0; indata = '0; load = 0; store = 0; ime_set = 0; ime_clr = 0; intack = 0;
    ints = '0;
    a8 = '0; d8 = '0; ld8 = 0; st8 = 0; is8 = 0; ic8 = 0; ack8 = 0; ints8 = '0;

    //         st  addr      data  ld ints   set clr ack  req vec       wk if     out
    tbl[0]  = '{1, 16'hffff, 8'h1F, 0, 5'h00, 0, 0, 0,  0, 16'h0000, 0, 5'h00, 8'h00};
    tbl[1]  = '{0, 16'h0000, 8'h00, 0, 5'h00, 1, 0, 0,  0, 16'h0000, 0, 5'h00, 8'h00};
    tbl[2]  = '{0, 16'hff0f, 8'h00, 1, 5'h04, 0, 0, 0,  1, 16'h0050, 1, 5'h04, 8'hE4};
    tbl[3]  = '{0, 16'h0000, 8'h00, 0, 5'h04, 0, 0, 1,  0, 16'h0000, 0, 5'h00, 8'h00};
    tbl[4]  = '{0, 16'h0000, 8'h00, 0, 5'h00, 0, 0, 0,  0, 16'h0000, 0, 5'h00, 8'h00};
    tbl[5]  = '{0, 16'h0000, 8'h00, 0, 5'h00, 1, 0, 0,  0, 16'h0000, 0, 5'h00, 8'h00};
    tbl[6]  = '{0, 16'h0000, 8'h00, 0, 5'h0A, 0, 0, 0,  1, 16'h0048, 1, 5'h0A, 8'h00};
    tbl[7]  = '{0, 16'h0000, 8'h00, 0, 5'h0A, 0, 0, 1,  0, 16'h0000, 1, 5'h08, 8'h00};
    tbl[8]  = '{0, 16'h0000, 8'h00, 0, 5'h0A, 1, 0, 0,  0, 16'h0000, 1, 5'h08, 8'h00};
    tbl[9]  = '{0, 16'hff0f, 8'h00, 1, 5'h0A, 0, 0, 0,  1, 16'h0058, 1, 5'h08, 8'hE8};
    tbl[10] = '{0, 16'h0000, 8'h00, 0, 5'h0A, 0, 0, 1,  0, 16'h0000, 0, 5'h00, 8'h00};
    tbl[11] = '{1, 16'hff0f, 8'h00, 0, 5'h0B, 0, 0, 0,  0, 16'h0000, 1, 5'h01, 8'h00};
    tbl[12] = '{0, 16'h0000, 8'h00, 0, 5'h0B, 1, 0, 0,  0, 16'h0000, 1, 5'h01, 8'h00};
    tbl[13] = '{0, 16'h0000, 8'h00, 0, 5'h0B, 0, 0, 0,  1, 16'h0040, 1, 5'h01, 8'h00};
    tbl[14] = '{0, 16'h0000, 8'h00, 0, 5'h0A, 0, 0, 0,  1, 16'h0040, 1, 5'h01, 8'h00};
    tbl[15] = '{0, 16'h0000, 8'h00, 0, 5'h0B, 0, 0, 1,  0, 16'h0000, 1, 5'h01, 8'h00};
    tbl[16] = '{1, 16'hffff, 8'h04, 0, 5'h0B, 0, 0, 0,  0, 16'h0000, 0, 5'h01, 8'h00};
    tbl[17] = '{1, 16'hff0f, 8'h00, 0, 5'h0B, 0, 0, 0,  0, 16'h0000, 0, 5'h00, 8'h00};
    tbl[18] = '{0, 16'h0000, 8'h00, 0, 5'h0F, 0, 0, 0,  0, 16'h0000, 1, 5'h04, 8'h00};
    tbl[19] = '{0, 16'h0000, 8'h00, 0, 5'h0F, 1, 1, 0,  0, 16'h0000, 1, 5'h04, 8'h00};
    tbl[20] = '{0, 16'hffff, 8'h00, 1, 5'h0F, 0, 0, 0,  0, 16'h0000, 1, 5'h04, 8'h04};
    tbl[21] = '{1, 16'hff0f, 8'h00, 0, 5'h00, 0, 0, 0,  0, 16'h0000, 0, 5'h00, 8'h00};

    #12;
    chk_main("reset", 1'b0, 16'h0000, 1'b0, 5'h00);
    load = 1'b1; address = 16'hff0f; #1;
    chk("reset.outdata", 32'(outdata), 32'h0);
    load = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 22; k++) begin
      store = tbl[k].st; address = tbl[k].addr; indata = tbl[k].data; load = tbl[k].ld;
      ints = tbl[k].ints; ime_set = tbl[k].set; ime_clr = tbl[k].clr; intack = tbl[k].ack;
      tick();
      #1;
      chk_main($sformatf("row%0d", k), tbl[k].e_req, tbl[k].e_vec, tbl[k].e_wake, tbl[k].e_if);
      chk($sformatf("row%0d.outdata", k), 32'(outdata), 32'(tbl[k].e_out));
      $display("row %0d: intreq=%0b intaddress=%h wake=%0b dints=%h outdata=%h",
               k, intreq, intaddress, wake, dints, outdata);
    end
    load = 1'b0;

    // Source held high across an ack must not re-flag; a fall then rise does.
    store = 1'b1; address = 16'hffff; indata = 8'h1F; tick();
    ime_set = 1'b1; tick(); tick();
    ints = 5'h10; tick();
    chk_main("held.rise", 1'b1, 16'h0060, 1'b1, 5'h10);
    intack = 1'b1; tick();
    chk_main("held.ack", 1'b0, 16'h0000, 1'b0, 5'h00);
    ime_set = 1'b1; tick(); tick();
    chk_main("held.noreflag", 1'b0, 16'h0000, 1'b0, 5'h00);
    ints = 5'h00; tick();
    ints = 5'h10; tick();
    chk_main("held.reflag", 1'b1, 16'h0060, 1'b1, 5'h10);
    $display("seq held: intreq=%0b intaddress=%h dints=%h", intreq, intaddress, dints);

    // Asynchronous reset in the middle of a request, with an ack on the way.
    intack = 1'b1; ime_set = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk_main("rst.mid", 1'b0, 16'h0000, 1'b0, 5'h00);
    intack = 1'b0; ime_set = 1'b0;
    load = 1'b1; address = 16'hff0f; #1;
    chk("rst.mid.outdata", 32'(outdata), 32'h0);
    load = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk_main("rst.highline", 1'b0, 16'h0000, 1'b0, 5'h10);
    $display("seq reset: intreq=%0b dints=%h", intreq, dints);

    // Eight-source instance with a relocated vector table.
    st8 = 1'b1; a8 = 16'hffff; d8 = 8'hFF; tick();
    is8 = 1'b1; tick(); tick();
    ints8 = 8'h80; tick();
    chk("n8.intreq", 32'(rq8), 32'h1);
    chk("n8.intaddress", 32'(ia8), 32'h0170);
    chk("n8.dints", 32'(di8), 32'h80);
    ld8 = 1'b1; a8 = 16'hff0f; #1;
    chk("n8.if_read", 32'(od8), 32'h80);
    a8 = 16'hffff; #1;
    chk("n8.ie_read", 32'(od8), 32'hFF);
    ld8 = 1'b0;
    $display("seq n8: intreq=%0b intaddress=%h", rq8, ia8);

    // Randomized traffic checked against the reference model.
    resetn = 1'b0; ints = '0;
    #3;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) ints = 5'($urandom);
      case ($urandom_range(0, 2))
        0:       address = 16'hff0f;
        1:       address = 16'hffff;
        default: address = 16'($urandom);
      endcase
      indata  = 8'($urandom);
      store   = ($urandom_range(0, 7) == 0);
      load    = ($urandom_range(0, 1) == 0);
      ime_set = ($urandom_range(0, 3) == 0);
      ime_clr = ($urandom_range(0, 15) == 0);
      intack  = ($urandom_range(0, 2) == 0);
      #1;
      model_check(c);
      model_step();
      @(posedge clk);
      #1;
    end
    store = 0; load = 0; ime_set = 0; ime_clr = 0; intack = 0;
    $display("random phase: 600 cycles compared");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
